mdu_unit: RTL

- Parametrised multiply/divide unit for the next-generation MIPS datapath. It sits beside the ALU in the execute stage.
- Executes MULT/MULTU/DIV/DIVU over a configurable number of cycles, holding results in internal HI/LO registers.
- Also supports MTHI/MTLO writes and MFHI/MFLO reads.
- Exposes busy/stall signalling so the controller can hold dependent instructions.

---
 rtl/mdu_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO/MFHI/MFLO access
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             stall
);
    localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(NMAX + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
    logic [1:0]       r_op;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             w_sgn, w_a_neg, w_b_neg, w_div0;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_uq, w_ur, w_hi_n, w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    // Sign-extending both operands to 2*WIDTH lets one multiplier serve MULT and MULTU.
    // Most-negative / -1 needs no special case: the magnitude quotient is already 0x80..0 with positive sign.
    always_comb begin
        w_sgn   = ~r_op[0];
        w_a_neg = w_sgn & r_a[WIDTH-1];
        w_b_neg = w_sgn & r_b[WIDTH-1];
        w_div0  = (r_b == '0);
        w_abs_a = w_a_neg ? -r_a : r_a;
        w_abs_b = w_div0 ? WIDTH'(1) : (w_b_neg ? -r_b : r_b);
        w_uq    = w_abs_a / w_abs_b;
        w_ur    = w_abs_a % w_abs_b;
        w_prod  = {{WIDTH{w_a_neg}}, r_a} * {{WIDTH{w_b_neg}}, r_b};
        w_lo_n  = r_op[1] ? ((w_a_neg ^ w_b_neg) ? -w_uq : w_uq) : w_prod[WIDTH-1:0];
        w_hi_n  = r_op[1] ? (w_a_neg ? -w_ur : w_ur) : w_prod[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else if (r_state == IDLE) begin
            if (start && !op[2]) begin
                r_a     <= A;
                r_b     <= B;
                r_op    <= op[1:0];
                r_cnt   <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_state <= RUN;
                r_busy  <= 1'b1;
            end else if (start && op == 3'd4) begin
                r_hi <= A;
            end else if (start && op == 3'd5) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                if (!(r_op[1] && w_div0)) begin
                    r_hi <= w_hi_n;
                    r_lo <= w_lo_n;
                end
            end
        end
    end
    assign HI      = r_hi;
    assign LO      = r_lo;
    assign busy    = r_busy;
    assign stall   = r_busy | (start & ~op[2]);
    assign rd_data = rd_sel ? r_hi : r_lo;
endmodule
